reg_bank_dump_reader: RTL and testbench
=======================================

Name: reg_bank_dump_reader

Overview:
- Debug/scan initiator for the 32-entry register bank.
- On a start pulse it walks the bank's read port from register 0 to REG_TOTAL-1. For each register it presents the address, captures the combinational read data and streams the word out on a valid/ready handshake.
- Sits beside the datapath and owns the bank's second read port (ReadReg2/ReadData2) while busy. The debug/trace logic is the consumer.

Parameters:
- WORD_SIZE, 32, width of a register word.
- REG_ADDR_W, 5, register address width.
- REG_TOTAL, 32, number of registers dumped; must equal 2**REG_ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses.
- done  out  1  one-cycle pulse after the final word handshakes.
- rd_addr  out  REG_ADDR_W  to the bank's ReadReg2.
- rd_data  in  WORD_SIZE  from the bank's ReadData2; combinational in rd_addr.
- out_valid  out  1  out_data/out_index/out_last are valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WORD_SIZE  captured register word.
- out_index  out  REG_ADDR_W  register number of out_data.
- out_last  out  1  marks the final word of the dump.

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=0; all outputs 0 (busy, done, rd_addr, out_valid, out_data, out_index, out_last). Reset mid-dump aborts with no done pulse.
- FSM states: IDLE, LOAD, SEND, DONE (plus CSUM with the option enabled).
- IDLE: rd_addr=0. start=1 -> LOAD, idx<=0, busy<=1.
- LOAD (one cycle): rd_addr=idx; out_data<=rd_data, out_index<=idx, out_valid<=1, out_last<=(idx==REG_TOTAL-1) -> SEND.
- SEND: rd_addr holds idx; outputs held stable while out_valid & !out_ready. On out_ready:
  - out_valid<=0, out_last<=0.
  - idx==REG_TOTAL-1 -> DONE.
  - otherwise idx<=idx+1 -> LOAD.
- DONE (one cycle): done=1, busy<=0 -> IDLE.
- Latency and throughput:
  - First out_valid 2 cycles after start is sampled (start edge -> LOAD, LOAD edge -> valid).
  - Maximum throughput is one word per 2 cycles with out_ready tied high.
  - Full dump with ready high: 2*REG_TOTAL+1 cycles from start to done.
- start asserted while busy, including in the DONE cycle: ignored.
- idx never wraps. Termination is compare-based at REG_TOTAL-1.
- Dump is not atomic. A bank write to a register not yet captured appears in the dump; a write to an already-captured register does not.
- out_ready while out_valid=0: no effect.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - Internal WORD_SIZE accumulator csum, cleared on start and reset; XORed with rd_data in every LOAD.
  - out_last is NOT set on register REG_TOTAL-1. After that word handshakes, FSM enters CSUM: out_data=csum^(final rd_data folded in), out_index=0, out_last=1, out_valid=1, held until out_ready -> DONE.
  - Full dump adds 2 cycles with ready high.
- Undefined: no accumulator, no CSUM state; out_last accompanies register REG_TOTAL-1.

Decomposition:
- Shared package reg_dump_pkg holds:
  - WORD_SIZE, REG_ADDR_W, REG_TOTAL defaults.
  - The state enum: IDLE, LOAD, SEND, CSUM, DONE.
  - DUMP_STATE_W.
- No sub-module is natural. The checksum is one XOR register and stays inline.

Test Plan:
- Bank preloaded reg i = 0x1000_0000+i, out_ready=1, pulse start:
  - 32 words in order, out_index 0..31, data matching.
  - out_last only on index 31; done exactly once, at cycle 65 after start.
- Backpressure: out_ready low for 5 cycles on index 7:
  - out_data=0x1000_0007 and out_index=7 held stable; rd_addr stays 7; word accepted once; index 8 follows.
- start re-pulsed at index 12 and in the DONE cycle: no restart, sequence unchanged, single done.
- rst low while presenting index 20:
  - All outputs 0 immediately (async).
  - After release, a fresh start dumps from index 0.
- Write reg 30 = 0xCAFE_F00D during the dump at index 10: index 30 reports 0xCAFE_F00D. Write reg 3 at index 10: index 3 already reported the old value.
- With REG_DUMP_CHECKSUM_EN, all regs 0xDEAD_BEEF except reg 5 = 0x0000_0001:
  - 33rd word 0xDEAD_BEEE with out_last=1 and out_index=0.
  - out_last low on index 31.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared types and default sizes for the register bank dump reader.
package reg_dump_pkg;
    localparam int WORD_SIZE    = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_TOTAL    = 32;
    localparam int DUMP_STATE_W = 3;

    typedef enum logic [DUMP_STATE_W-1:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } dump_state_t;
endpackage

// File: rtl/reg_bank_dump_reader.sv
// Walks the register bank's second read port and streams every word out on valid/ready.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module reg_bank_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int WORD_SIZE  = reg_dump_pkg::WORD_SIZE,
    parameter int REG_ADDR_W = reg_dump_pkg::REG_ADDR_W,
    parameter int REG_TOTAL  = reg_dump_pkg::REG_TOTAL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [WORD_SIZE-1:0]  rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_data,
    output logic [REG_ADDR_W-1:0] out_index,
    output logic                  out_last
);

    dump_state_t           state_q, state_d;
    logic [REG_ADDR_W-1:0] idx;
    logic                  last_idx;

    assign last_idx = (idx == REG_ADDR_W'(REG_TOTAL - 1));

`ifdef REG_DUMP_CHECKSUM_EN
    logic [WORD_SIZE-1:0] csum;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        rd_addr = idx;
        case (state_q)
            IDLE: begin
                rd_addr = '0;
                if (start) state_d = LOAD;
            end
            LOAD: state_d = SEND;
            SEND: begin
                if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    state_d = last_idx ? CSUM : LOAD;
`else
                    state_d = last_idx ? DONE : LOAD;
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: if (out_valid && out_ready) state_d = DONE;
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx  <= '0;
                        busy <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum <= '0;
`endif
                    end
                end
                LOAD: begin
                    // Capture here so later bank writes to this register are not seen.
                    out_data  <= rd_data;
                    out_index <= idx;
                    out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    csum      <= csum ^ rd_data;
`else
                    out_last  <= last_idx;
`endif
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!last_idx) idx <= idx + 1'b1;
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                CSUM: begin
                    // First cycle presents the checksum, then it waits for the handshake.
                    if (!out_valid) begin
                        out_data  <= csum;
                        out_index <= '0;
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
`endif
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_dump_reader.sv
// Directed bench for reg_bank_dump_reader with a behavioural 32-entry bank on the read port.
module tb_reg_bank_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NWORDS   = 33;
    localparam int DONE_LAT = 66;
`else
    localparam int NWORDS   = 32;
    localparam int DONE_LAT = 64;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rd_addr, out_index;
    logic [31:0] rd_data, out_data;
    logic [31:0] bank [32];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [4:0]  q_idx [$];
    logic [31:0] q_data[$];
    logic        q_last[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          first_v  = -1;

    assign rd_data = bank[rd_addr];

    reg_bank_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Inputs change just after posedge, so negedge sees what the next edge will see.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_idx.push_back(out_index);
            q_data.push_back(out_data);
            q_last.push_back(out_last);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid && first_v < 0) first_v = cyc;
    end

    task automatic clear_log();
        q_idx.delete(); q_data.delete(); q_last.delete();
        done_cnt = 0; first_v = -1;
    endtask

    task automatic fill_bank();
        for (int i = 0; i < 32; i++) bank[i] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!busy && done_cnt > 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_word(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (out_valid && out_index == 5'(n)) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rd_addr !== 5'd0)   begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_index !== 5'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", out_index); end
        checks++; if (out_last !== 1'b0)  begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_full_dump();
        int s; bit ok; int bad;
        logic [31:0] exp_d;
        fill_bank(); clear_log(); out_ready = 1'b1;
        pulse_start(s);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_high got=%b exp=1", busy); end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=busy exp=idle"); end
        checks++; if (q_idx.size() != NWORDS) begin failures++; $display("FAIL full_count got=%0d exp=%0d", q_idx.size(), NWORDS); end
        bad = 0;
        for (int i = 0; i < NWORDS && i < q_idx.size(); i++) begin
            exp_d = (i < 32) ? 32'h1000_0000 + 32'(i) : 32'h0;  // XOR of 0x1000_0000+i over 32 regs is 0
            if (q_idx[i] !== ((i < 32) ? 5'(i) : 5'd0) || q_data[i] !== exp_d || q_last[i] !== (i == NWORDS - 1)) begin
                bad++;
                $display("FAIL full_word%0d got=%0d/%h/%b exp=%h", i, q_idx[i], q_data[i], q_last[i], exp_d);
            end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL full_words got=%0d_bad exp=0", bad); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_cyc - s != DONE_LAT) begin failures++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc - s, DONE_LAT); end
        checks++; if (first_v - s != 1) begin failures++; $display("FAIL full_first_valid got=%0d exp=1", first_v - s); end
    endtask

    task automatic test_backpressure();
        int s; bit ok; bit found;
        fill_bank(); clear_log(); out_ready = 1'b1;
        pulse_start(s);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (busy && !out_valid && rd_addr == 5'd7) begin found = 1'b1; out_ready = 1'b0; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL bp_find_load7 got=0 exp=1"); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h1000_0007 || out_index !== 5'd7 || rd_addr !== 5'd7) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b/%h/%0d/%0d exp=1/10000007/7/7", k, out_valid, out_data, out_index, rd_addr);
            end
        end
        out_ready = 1'b1;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=busy exp=idle"); end
        checks++; if (q_idx.size() != NWORDS) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", q_idx.size(), NWORDS); end
        if (q_idx.size() > 8) begin
            checks++; if (q_idx[7] !== 5'd7 || q_idx[8] !== 5'd8) begin failures++; $display("FAIL bp_order got=%0d,%0d exp=7,8", q_idx[7], q_idx[8]); end
        end
    endtask

    task automatic test_start_ignored();
        int s; bit ok; int bad;
        fill_bank(); clear_log(); out_ready = 1'b1;
        pulse_start(s);
        wait_word(12, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ign_find12 got=0 exp=1"); end
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL ign_done_timeout got=0 exp=1"); end
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_restart got=busy%b exp=0", busy); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
        bad = 0;
        for (int i = 0; i < q_idx.size() && i < 32; i++) if (q_idx[i] !== 5'(i)) bad++;
        checks++; if (bad != 0 || q_idx.size() != NWORDS) begin failures++; $display("FAIL ign_sequence got=%0d_bad/%0d exp=0/%0d", bad, q_idx.size(), NWORDS); end
    endtask

    task automatic test_reset_abort();
        int s; bit ok;
        fill_bank(); clear_log(); out_ready = 1'b1;
        pulse_start(s);
        wait_word(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_find20 got=0 exp=1"); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0 || out_valid !== 1'b0 ||
            out_data !== 32'd0 || out_index !== 5'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs got=%b%b/%0d/%b/%h/%0d/%b exp=all_zero", busy, done, rd_addr, out_valid, out_data, out_index, out_last);
        end
        repeat (3) @(posedge clk); #1 rst = 1'b1;
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
        clear_log();
        pulse_start(s);
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_restart_timeout got=busy exp=idle"); end
        checks++;
        if (q_idx.size() != NWORDS || q_idx[0] !== 5'd0 || q_data[0] !== 32'h1000_0000) begin
            failures++;
            $display("FAIL abort_fresh got=%0d/%0d/%h exp=%0d/0/10000000", q_idx.size(), q_idx[0], q_data[0], NWORDS);
        end
    endtask

    task automatic test_write_during_dump();
        int s; bit ok;
        fill_bank(); clear_log(); out_ready = 1'b1;
        pulse_start(s);
        wait_word(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr_find10 got=0 exp=1"); end
        bank[30] = 32'hCAFE_F00D;
        bank[3]  = 32'h0BAD_0003;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr_timeout got=busy exp=idle"); end
        if (q_data.size() > 30) begin
            checks++; if (q_data[30] !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr_reg30 got=%h exp=cafef00d", q_data[30]); end
            checks++; if (q_data[3] !== 32'h1000_0003) begin failures++; $display("FAIL wr_reg3 got=%h exp=10000003", q_data[3]); end
        end else begin
            checks++; failures++; $display("FAIL wr_count got=%0d exp=%0d", q_data.size(), NWORDS);
        end
        fill_bank();
    endtask

`ifdef REG_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        int s; bit ok;
        for (int i = 0; i < 32; i++) bank[i] = 32'hDEAD_BEEF;
        bank[5] = 32'h0000_0001;
        clear_log(); out_ready = 1'b1;
        pulse_start(s);
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL cs_timeout got=busy exp=idle"); end
        if (q_data.size() == 33) begin
            checks++; if (q_data[32] !== 32'hDEAD_BEEE) begin failures++; $display("FAIL cs_value got=%h exp=deadbeee", q_data[32]); end
            checks++; if (q_idx[32] !== 5'd0 || q_last[32] !== 1'b1) begin failures++; $display("FAIL cs_tag got=%0d/%b exp=0/1", q_idx[32], q_last[32]); end
            checks++; if (q_last[31] !== 1'b0) begin failures++; $display("FAIL cs_last31 got=%b exp=0", q_last[31]); end
        end else begin
            checks++; failures++; $display("FAIL cs_count got=%0d exp=33", q_data.size());
        end
        fill_bank();
    endtask
`endif

    initial begin
        fill_bank();
        repeat (2) @(posedge clk);
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_ignored();
        test_reset_abort();
        test_write_during_dump();
`ifdef REG_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
